imem_loader: RTL and testbench
==============================

# imem_loader

Program loader for the single-cycle core's instruction memory. It accepts a byte stream on a valid/ready interface, reads a 16-bit word-count header, and assembles little-endian 32-bit instruction words. It writes each word into the instruction memory through a word-aligned byte-address write port, so a test image can be placed at word 0 upward. `busy` holds the core in reset while a load is in progress.

## Interface
- `DEPTH`, 256: instruction memory size in 32-bit words (1024 bytes).
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1: `in_data` holds a byte.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte this cycle. Transfer occurs when `in_valid & in_ready`.
- `we`  out  1: instruction memory write strobe, asserted for one cycle per word.
- `waddr`  out  32: byte address of the word being written, always word-aligned (`idx << 2`).
- `wdata`  out  32: assembled instruction word.
- `busy`  out  1: load in progress (LEN0 through WRITE).
- `done`  out  1: last load completed; sticky until next `start`.
- `err`  out  1: header rejected; sticky until next `start`.
- `words_written`  out  16: words written by the current or last load.

## Operation
- States:
  - IDLE: no load active.
  - LEN0: expecting header byte 0.
  - LEN1: expecting header byte 1.
  - DATA: collecting the bytes of one word.
  - WRITE: writing the assembled word.
  - DONE: load completed.
  - ERR: header rejected.
- IDLE/DONE/ERR, `start`=1 → LEN0. This transition clears `done`, `err`, `words_written`, the word index and the byte counter.
- LEN0: the accepted byte goes to N[7:0] → LEN1.
- LEN1: the accepted byte goes to N[15:8]. The next state depends on the complete N:
  - N > DEPTH → ERR. No write occurs.
  - N = 0 → DONE. No write occurs.
  - Otherwise → DATA.
- DATA: the k-th accepted byte (k = 0..3) goes to `wdata[8k+7:8k]`, so the first byte is the LSB. After the 4th byte → WRITE.
- WRITE:
  - `we`=1 for exactly one cycle, with `waddr` = idx·4 and `wdata` stable.
  - At the end of the cycle, idx and `words_written` increment.
  - → DONE if the incremented idx equals N, else → DATA with the byte counter at 0.
- `in_ready` is 1 only in LEN0, LEN1 and DATA; it is 0 in WRITE, IDLE, DONE and ERR. Bytes offered while `in_ready`=0 are not consumed.
- `in_valid`=0 in an accepting state: the loader stalls indefinitely with no state change.
- `start` while `busy`=1 is ignored.
- Width rules:
  - idx and N are 16 bits.
  - The comparison N > DEPTH is unsigned.
  - `waddr` upper bits are zero-extended.
- Reset (asynchronous, any state, including mid-word or mid-WRITE) → IDLE. All outputs 0 (`in_ready`, `we`, `waddr`, `wdata`, `busy`, `done`, `err`, `words_written`). A partially assembled word is discarded.

## Timing
- A byte accepted at edge t is visible in the registered state after t.
- The 4th data byte is accepted at edge t. WRITE (`we`=1) occupies cycle t..t+1. `in_ready` returns to 1 at t+1.
- Peak throughput is 5 cycles per word: 4 accepting cycles plus 1 WRITE cycle.
- The final WRITE ends at edge w. `done`=1 and `busy`=0 from w.
- ERR and zero-length DONE are entered at the edge that accepts header byte 1.
- All outputs are registered or state-decoded; there is no combinational path from `in_valid` to `in_ready`.

## Test plan
- Reset values: hold `rst_n`=0, then release → all outputs 0 and `in_ready`=0. With no `start`, `in_valid`=1 stays unconsumed for 20 cycles.
- Two-word load:
  - Stimulus: `start`, then bytes 02 00, 13 05 50 00, 93 05 60 00.
  - Required response: `we` pulses at `waddr`=0 with `wdata`=0x00500513 and at `waddr`=4 with `wdata`=0x00600593.
  - Then `done`=1, `words_written`=2, `in_ready`=0.
- Backpressure: same image as the two-word load, with `in_valid` toggled randomly. Required: identical writes, and no byte is accepted during WRITE.
- Header errors:
  - Header 01 01 (N=257) → `err`=1 with no `we`.
  - Header 00 00 → `done`=1 with `words_written`=0.
  - A subsequent `start` clears both.
- Reset mid-operation: assert `rst_n`=0 after 2 bytes of word 1 of a 3-word load → all outputs 0 and state IDLE. A new full load then writes correctly from address 0.
- Full memory: N=256 with an incrementing word pattern. Required: the last write is at `waddr`=1020, and reading back addresses 0..1020 step 4 matches the pattern.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master side feeds bytes and observes writes; the slave side is the loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  we,
    input  waddr,
    input  wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output we,
    output waddr,
    output wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory program loader: reads a 16-bit little-endian word count,
// then assembles little-endian 32-bit words and writes them from word 0 upward.
// busy is meant to hold the core in reset while a load is running.
module imem_loader #(
  parameter int unsigned DEPTH = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  imem_loader_if.slave   bus,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [15:0]    words_written
);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state;
  logic [15:0] n;
  logic [15:0] idx;
  logic [1:0]  cnt;
  logic        in_ready_q;
  logic        we_q;
  logic [31:0] waddr_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic [15:0] hdr_n;
  logic [15:0] idx_inc;

  // in_ready is a register, so accept never loops back into it combinationally.
  assign accept  = bus.in_valid & in_ready_q;
  // Full word count as it will be once the second header byte is taken.
  assign hdr_n   = {bus.in_data, n[7:0]};
  assign idx_inc = idx + 16'd1;

  assign bus.in_ready  = in_ready_q;
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign words_written = idx;

  // Loader FSM; every output is updated together with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      n          <= '0;
      idx        <= '0;
      cnt        <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN0;
            in_ready_q <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
          end
        end

        LEN0: begin
          if (accept) begin
            n[7:0] <= bus.in_data;
            state  <= LEN1;
          end
        end

        LEN1: begin
          if (accept) begin
            n[15:8] <= bus.in_data;
            if ({1'b0, hdr_n} > DEPTH_W) begin
              state      <= ERR;
              err        <= 1'b1;
              busy       <= 1'b0;
              in_ready_q <= 1'b0;
            end else if (hdr_n == 16'd0) begin
              state      <= DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              in_ready_q <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (accept) begin
            wdata_q[{cnt, 3'b000} +: 8] <= bus.in_data;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state      <= WRITE;
              we_q       <= 1'b1;
              in_ready_q <= 1'b0;
              waddr_q    <= {14'b0, idx, 2'b00};
            end
          end
        end

        WRITE: begin
          we_q <= 1'b0;
          idx  <= idx_inc;
          if (idx_inc == n) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state      <= DATA;
            in_ready_q <= 1'b1;
            cnt        <= '0;
          end
        end

        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b0;
          we_q       <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a driver feeds byte images and pushes the expected
// memory writes into a queue; a monitor pops and compares on every we pulse.
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_written;

  imem_loader_if ifc ();

  imem_loader #(.DEPTH(256)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .bus           (ifc.slave),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [63:0] exp_q[$];
  logic [31:0] mem [256];
  logic [31:0] last_waddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && ifc.we) begin
      logic [63:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", ifc.waddr, ifc.wdata);
      end else begin
        e = exp_q.pop_front();
        if ({ifc.waddr, ifc.wdata} !== e) begin
          n_err++;
          $display("FAIL write: got addr %h data %h expected addr %h data %h",
                   ifc.waddr, ifc.wdata, e[63:32], e[31:0]);
        end
      end
      n_cmp++;
      if (ifc.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL ready_in_write: got %b expected 0", ifc.in_ready);
      end
      mem[ifc.waddr[9:2]] = ifc.wdata;
      last_waddr = ifc.waddr;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte and holds it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input bit bp);
    int unsigned guard = 0;
    if (bp) begin
      while ($urandom_range(0, 1) == 1) begin
        ifc.in_valid = 1'b0;
        @(negedge clk);
      end
    end
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    while (ifc.in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL byte_timeout: got in_ready %b expected 1", ifc.in_ready);
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit bp);
    for (int unsigned k = 0; k < 4; k++) begin
      logic [31:0] t;
      t = w >> (8 * k);
      send_byte(t[7:0], bp);
    end
  endtask

  task automatic wait_finish(input int unsigned limit);
    int unsigned g = 0;
    while (!done && !err && g < limit) begin
      @(negedge clk);
      g++;
    end
    if (g >= limit) begin
      n_cmp++;
      n_err++;
      $display("FAIL finish_timeout: got done %b err %b expected one set", done, err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] img2 [2];
    img2[0] = 32'h0050_0513;
    img2[1] = 32'h0060_0593;

    rst_n        = 1'b0;
    start        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_in_ready", {31'b0, ifc.in_ready}, 32'd0);
    chk("rst_we",       {31'b0, ifc.we},       32'd0);
    chk("rst_waddr",    ifc.waddr,             32'd0);
    chk("rst_wdata",    ifc.wdata,             32'd0);
    chk("rst_flags",    {29'b0, busy, done, err}, 32'd0);
    chk("rst_words",    {16'b0, words_written}, 32'd0);
    rst_n = 1'b1;

    // No start: offered bytes stay unconsumed
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'hAA;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ready", {30'b0, ifc.in_ready, busy}, 32'd0);
    end
    ifc.in_valid = 1'b0;

    // Two-word load
    pulse_start();
    chk("start_ready_busy", {30'b0, ifc.in_ready, busy}, 32'd3);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    exp_q.push_back({32'd0, img2[0]});
    exp_q.push_back({32'd4, img2[1]});
    send_word(img2[0], 0);
    send_word(img2[1], 0);
    wait_finish(50);
    chk("two_done",  {31'b0, done}, 32'd1);
    chk("two_words", {16'b0, words_written}, 32'd2);
    chk("two_ready", {30'b0, ifc.in_ready, busy}, 32'd0);

    // Backpressure, plus a start pulse mid-load that must be ignored
    pulse_start();
    send_byte(8'h02, 1);
    send_byte(8'h00, 1);
    exp_q.push_back({32'd0, img2[0]});
    exp_q.push_back({32'd4, img2[1]});
    send_byte(8'h13, 1);
    send_byte(8'h05, 1);
    pulse_start();
    send_byte(8'h50, 1);
    send_byte(8'h00, 1);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h93;
    send_word(img2[1], 1);
    wait_finish(100);
    chk("bp_done",  {31'b0, done}, 32'd1);
    chk("bp_words", {16'b0, words_written}, 32'd2);

    // Header N=257 is rejected
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("n257_flags", {29'b0, busy, done, err}, 32'd1);
    chk("n257_ready", {31'b0, ifc.in_ready}, 32'd0);

    // Header N=0 completes immediately
    pulse_start();
    chk("restart_clears_err", {29'b0, busy, done, err}, 32'd4);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("n0_flags", {29'b0, busy, done, err}, 32'd2);
    chk("n0_words", {16'b0, words_written}, 32'd0);

    pulse_start();
    chk("restart_clears_done", {29'b0, busy, done, err}, 32'd4);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);

    // Reset in the middle of the first word of a 3-word load
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, ifc.in_ready}, 32'd0);
    chk("mid_rst_wdata", ifc.wdata, 32'd0);
    chk("mid_rst_flags", {28'b0, ifc.we, busy, done, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {30'b0, ifc.in_ready, busy}, 32'd0);

    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    exp_q.push_back({32'd0, 32'hA1B2_C3D4});
    exp_q.push_back({32'd4, 32'h0000_0000});
    exp_q.push_back({32'd8, 32'hFFFF_FFFF});
    send_word(32'hA1B2_C3D4, 0);
    send_word(32'h0000_0000, 0);
    send_word(32'hFFFF_FFFF, 0);
    wait_finish(100);
    chk("three_words", {16'b0, words_written}, 32'd3);
    chk("three_last",  last_waddr, 32'd8);

    // Full memory: N=256, word i holds 0x0BAD0000 + i
    for (int unsigned i = 0; i < 256; i++) mem[i] = 32'hDEAD_BEEF;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int unsigned i = 0; i < 256; i++) begin
      exp_q.push_back({32'(i * 4), 32'h0BAD_0000 + 32'(i)});
      send_word(32'h0BAD_0000 + 32'(i), 0);
    end
    wait_finish(100);
    chk("full_flags", {29'b0, busy, done, err}, 32'd2);
    chk("full_words", {16'b0, words_written}, 32'd256);
    chk("full_last",  last_waddr, 32'd1020);
    for (int unsigned i = 0; i < 256; i++)
      chk("full_readback", mem[i], 32'h0BAD_0000 + 32'(i));

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
